// File: rtl/snake_hit_detect.sv
// -----------------------------------------------------------------------------
// snake_hit_detect
//
// Purpose:
//   Collision / apple detector for the snake game. On each snake move the new
//   head address is captured, then compared for one cycle against the four
//   obstacle blocks, the playfield border and the current target (apple).
//   A collision latches Game_Over. An apple hit raises a one-cycle
//   Reached_Target request for the target generator, bumps the BCD score and
//   grows the snake, with the length saturating at MAX_LEN.
//
//   Address format: [14:7] = x (8 bits), [6:0] = y (7 bits).
//
// Configuration macro:
//   WALL_COLLIDE_EN - when defined, a head on or beyond the border
//                     (x==0, x>=X_MAX, y==0, y>=Y_MAX) is a collision.
//                     When undefined, only the blocks end the game and the
//                     movement logic upstream is expected to wrap.
//
// Ports:
//   CLK             in   1   system clock
//   RESET           in   1   synchronous active-high reset
//   Restart         in   1   synchronous active-high game restart
//   Move_Tick       in   1   pulse: Head_Address has just updated
//   Head_Address    in   15  snake head {x,y}
//   Target_Address  in   15  current apple position
//   Block_Address1  in   15  obstacle 1
//   Block_Address2  in   15  obstacle 2
//   Block_Address3  in   15  obstacle 3
//   Block_Address4  in   15  obstacle 4
//   Reached_Target  out  1   one-cycle pulse: apple eaten
//   Game_Over       out  1   sticky collision flag
//   Score           out  16  4-digit BCD score, digit 3 in [15:12]
//   Snake_Length    out  6   current snake length
// -----------------------------------------------------------------------------
module snake_hit_detect #(
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 32,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Restart,
  input  logic        Move_Tick,
  input  logic [14:0] Head_Address,
  input  logic [14:0] Target_Address,
  input  logic [14:0] Block_Address1,
  input  logic [14:0] Block_Address2,
  input  logic [14:0] Block_Address3,
  input  logic [14:0] Block_Address4,
  output logic        Reached_Target,
  output logic        Game_Over,
  output logic [15:0] Score,
  output logic [5:0]  Snake_Length
);

  // FSM encoding
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  // Parameters narrowed to the widths they are compared against
  localparam logic [5:0] INIT_LEN_C = INIT_LEN[5:0];
  localparam logic [5:0] MAX_LEN_C  = MAX_LEN[5:0];
  localparam logic [7:0] X_MAX_C    = X_MAX[7:0];
  localparam logic [6:0] Y_MAX_C    = Y_MAX[6:0];

`ifdef WALL_COLLIDE_EN
  localparam logic WALL_EN_C = 1'b1;
`else
  localparam logic WALL_EN_C = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Add one to a 4-digit BCD value. Each digit wraps 9->0 and carries into the
  // next; 9999 wraps to 0000. A digit already above 9 is treated as 9 so a
  // corrupted value still recovers to legal BCD.
  function automatic logic [15:0] bcd_inc(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (res[i*4 +: 4] >= 4'd9) begin
          res[i*4 +: 4] = 4'd0;
          carry         = 1'b1;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return res;
  endfunction

  // Length grows by one per apple but never beyond MAX_LEN.
  function automatic logic [5:0] len_inc(input logic [5:0] len);
    logic [5:0] res;
    if (len >= MAX_LEN_C) begin
      res = MAX_LEN_C;
    end else begin
      res = len + 6'd1;
    end
    return res;
  endfunction

  // True when the address lies on or outside the playable border.
  function automatic logic is_border(input logic [14:0] addr);
    logic [7:0] x;
    logic [6:0] y;
    x = addr[14:7];
    y = addr[6:0];
    return (x == 8'd0) || (x >= X_MAX_C) || (y == 7'd0) || (y >= Y_MAX_C);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,     state_d;
  logic [14:0] head_q,      head_d;
  logic        reached_q,   reached_d;
  logic        game_over_q, game_over_d;
  logic [15:0] score_q,     score_d;
  logic [5:0]  len_q,       len_d;

  logic block_hit_s;
  logic border_hit_s;
  logic collide_s;
  logic target_hit_s;

  // Compare the captured head against obstacles, border and apple.
  always_comb begin
    block_hit_s  = (head_q == Block_Address1) || (head_q == Block_Address2) ||
                   (head_q == Block_Address3) || (head_q == Block_Address4);
    border_hit_s = is_border(head_q);
    collide_s    = block_hit_s || (WALL_EN_C && border_hit_s);
    target_hit_s = (head_q == Target_Address);
  end

  // Next-state and next-output logic for the RUN/CHECK/OVER controller.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    reached_d   = 1'b0;            // the request never lasts more than one cycle
    game_over_d = game_over_q;
    score_d     = score_q;
    len_d       = len_q;

    case (state_q)
      ST_RUN: begin
        if (Move_Tick) begin
          head_d  = Head_Address;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_CHECK: begin
        // Collision outranks an apple sitting on the same square.
        if (collide_s) begin
          game_over_d = 1'b1;
          state_d     = ST_OVER;
        end else if (target_hit_s) begin
          reached_d = 1'b1;
          score_d   = bcd_inc(score_q);
          len_d     = len_inc(len_q);
          state_d   = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_OVER: begin
        // Terminal until RESET or Restart.
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Registers with synchronous reset; RESET and Restart both start a new game.
  always_ff @(posedge CLK) begin
    if (RESET || Restart) begin
      state_q     <= ST_RUN;
      head_q      <= 15'd0;
      reached_q   <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= 16'h0000;
      len_q       <= INIT_LEN_C;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      reached_q   <= reached_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      len_q       <= len_d;
    end
  end

  assign Reached_Target = reached_q;
  assign Game_Over      = game_over_q;
  assign Score          = score_q;
  assign Snake_Length   = len_q;

endmodule

// File: tb/tb_snake_hit_detect.sv
// -----------------------------------------------------------------------------
// tb_snake_hit_detect
//
// Self-checking bench for snake_hit_detect. It runs a table of single moves
// with hand-computed results, a set of hand-written multi-cycle corner cases,
// and a randomized run checked against a score/length/game-over model.
// Border expectations follow the WALL_COLLIDE_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_snake_hit_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        move_tick;
  logic [14:0] head, target, b1, b2, b3, b4;
  logic        reached, game_over;
  logic [15:0] score;
  logic [5:0]  snake_len;

  int total = 0;
  int bad   = 0;

`ifdef WALL_COLLIDE_EN
  localparam bit WALL = 1'b1;
`else
  localparam bit WALL = 1'b0;
`endif

  always #5 clk = ~clk;

  snake_hit_detect dut (
    .CLK           (clk),
    .RESET         (reset),
    .Restart       (restart),
    .Move_Tick     (move_tick),
    .Head_Address  (head),
    .Target_Address(target),
    .Block_Address1(b1),
    .Block_Address2(b2),
    .Block_Address3(b3),
    .Block_Address4(b4),
    .Reached_Target(reached),
    .Game_Over     (game_over),
    .Score         (score),
    .Snake_Length  (snake_len)
  );

  // Hard stop if something goes badly wrong.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain integer score and length, and an over flag.
  // ---------------------------------------------------------------------------
  int m_score;
  int m_len;
  bit m_over;

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    int d;
    d = (s / 1000) % 10; r[15:12] = d[3:0];
    d = (s / 100)  % 10; r[11:8]  = d[3:0];
    d = (s / 10)   % 10; r[7:4]   = d[3:0];
    d = s % 10;          r[3:0]   = d[3:0];
    return r;
  endfunction

  function automatic bit m_collide(input logic [14:0] h);
    int x, y;
    bit border;
    x = int'(h[14:7]);
    y = int'(h[6:0]);
    border = (x == 0) || (x >= 159) || (y == 0) || (y >= 119);
    return (h == b1) || (h == b2) || (h == b3) || (h == b4) || (WALL && border);
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_len   = 3;
    m_over  = 1'b0;
  endtask

  task automatic model_move(input logic [14:0] h, input logic [14:0] t, output bit pulse);
    pulse = 1'b0;
    if (!m_over) begin
      if (m_collide(h)) begin
        m_over = 1'b1;
      end else if (h == t) begin
        pulse   = 1'b1;
        m_score = (m_score + 1) % 10000;
        if (m_len < 32) m_len++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change and outputs are sampled on the falling edge.
  // ---------------------------------------------------------------------------

  // One move: tick sampled at edge N; returns Reached_Target after edge N,
  // after edge N+1 (the pulse cycle) and after edge N+2.
  task automatic do_move(input logic [14:0] h, input logic [14:0] t,
                         output logic r_early, output logic r_pulse, output logic r_late);
    @(negedge clk);
    head      = h;
    target    = t;
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    r_early   = reached;
    @(negedge clk);
    r_pulse   = reached;
    @(negedge clk);
    r_late    = reached;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_over",  int'(game_over), 0);
    check("restart_score", int'(score),     0);
    check("restart_len",   int'(snake_len), 3);
    check("restart_pulse", int'(reached),   0);
    model_reset();
  endtask

  function automatic logic [14:0] xy(input int x, input int y);
    logic [14:0] a;
    a[14:7] = x[7:0];
    a[6:0]  = y[6:0];
    return a;
  endfunction

  typedef struct {
    logic [14:0] head;
    logic [14:0] target;
    logic        exp_pulse;
    logic        exp_over;
    logic [15:0] exp_score;
    logic [5:0]  exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic r_e, r_p, r_l;
    bit   exp_p;
    int   sel;

    reset     = 1'b1;
    restart   = 1'b0;
    move_tick = 1'b0;
    head      = 15'd0;
    target    = 15'd0;
    b1 = xy(10, 10);
    b2 = xy(11, 20);
    b3 = xy(12, 30);
    b4 = xy(13, 40);

    vecs[0] = '{xy(20, 20),  xy(55, 13),  1'b0, 1'b0, 16'h0000, 6'd3};
    vecs[1] = '{xy(55, 13),  xy(55, 13),  1'b1, 1'b0, 16'h0001, 6'd4};
    vecs[2] = '{xy(55, 13),  xy(55, 13),  1'b1, 1'b0, 16'h0002, 6'd5};
    vecs[3] = '{xy(30, 30),  xy(40, 40),  1'b0, 1'b0, 16'h0002, 6'd5};
    vecs[4] = '{xy(1, 1),    xy(1, 1),    1'b1, 1'b0, 16'h0003, 6'd6};
    vecs[5] = '{xy(158, 118), xy(158, 118), 1'b1, 1'b0, 16'h0004, 6'd7};
    vecs[6] = '{xy(10, 10),  xy(70, 70),  1'b0, 1'b1, 16'h0004, 6'd7};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_pulse", int'(reached),   0);
    check("reset_over",  int'(game_over), 0);
    check("reset_score", int'(score),     0);
    check("reset_len",   int'(snake_len), 3);

    // --- Table-driven single moves ---------------------------------------------
    foreach (vecs[i]) begin
      do_move(vecs[i].head, vecs[i].target, r_e, r_p, r_l);
      check($sformatf("tbl%0d_early", i), int'(r_e),       0);
      check($sformatf("tbl%0d_pulse", i), int'(r_p),       int'(vecs[i].exp_pulse));
      check($sformatf("tbl%0d_late",  i), int'(r_l),       0);
      check($sformatf("tbl%0d_over",  i), int'(game_over), int'(vecs[i].exp_over));
      check($sformatf("tbl%0d_score", i), int'(score),     int'(vecs[i].exp_score));
      check($sformatf("tbl%0d_len",   i), int'(snake_len), int'(vecs[i].exp_len));
    end

    // Ticks after game over are ignored.
    do_move(xy(70, 70), xy(70, 70), r_e, r_p, r_l);
    check("over_ignore_pulse", int'(r_p),       0);
    check("over_ignore_score", int'(score),     16'h0004);
    check("over_hold",         int'(game_over), 1);
    do_restart();

    // --- Block 3 and target on the same square: collision wins -------------------
    do_move(xy(12, 30), xy(12, 30), r_e, r_p, r_l);
    check("blk3_pulse", int'(r_p | r_e | r_l), 0);
    check("blk3_over",  int'(game_over),       1);
    check("blk3_score", int'(score),           0);
    check("blk3_len",   int'(snake_len),       3);
    do_move(xy(60, 60), xy(60, 60), r_e, r_p, r_l);
    check("blk3_after_pulse", int'(r_p | r_e | r_l), 0);
    check("blk3_after_len",   int'(snake_len),       3);
    do_restart();

    // --- Left border ---------------------------------------------------------
    do_move(xy(0, 50), xy(60, 60), r_e, r_p, r_l);
    check("wall_over",  int'(game_over), int'(WALL));
    check("wall_pulse", int'(r_p),       0);
    do_restart();

    // --- Tick held into the CHECK cycle is dropped ---------------------------
    @(negedge clk);
    head      = xy(20, 20);
    target    = xy(90, 90);
    move_tick = 1'b1;
    @(negedge clk);                 // edge N done, DUT in CHECK
    head = xy(90, 90);              // would hit if this tick were taken
    @(negedge clk);
    move_tick = 1'b0;
    sel = 0;
    repeat (4) begin
      if (reached) sel++;
      @(negedge clk);
    end
    check("dbl_tick_pulses", sel,             0);
    check("dbl_tick_score",  int'(score),     0);
    check("dbl_tick_len",    int'(snake_len), 3);

    // --- RESET during the CHECK cycle of a hit --------------------------------
    @(negedge clk);
    head      = xy(90, 90);
    target    = xy(90, 90);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_chk_pulse", int'(reached), 0);
    @(negedge clk);
    check("rst_chk_pulse2", int'(reached),   0);
    check("rst_chk_score",  int'(score),     0);
    check("rst_chk_len",    int'(snake_len), 3);
    model_reset();

    // --- 99 hits, then one more: BCD carry and length saturation --------------
    for (int i = 0; i < 99; i++) begin
      do_move(xy(100, 100), xy(100, 100), r_e, r_p, r_l);
      if (r_p !== 1'b1) check("bulk_pulse", int'(r_p), 1);
    end
    check("bcd_0099",  int'(score),     16'h0099);
    check("len_sat",   int'(snake_len), 32);
    do_move(xy(101, 100), xy(101, 100), r_e, r_p, r_l);
    check("bcd_0100_pulse", int'(r_p),       1);
    check("bcd_0100",       int'(score),     16'h0100);
    check("len_sat2",       int'(snake_len), 32);
    do_restart();

    // --- Randomized moves against the model -----------------------------------
    for (int i = 0; i < 250; i++) begin
      logic [14:0] h, t;
      b1 = xy($urandom_range(1, 158), $urandom_range(1, 118));
      b2 = xy($urandom_range(1, 158), $urandom_range(1, 118));
      b3 = xy($urandom_range(1, 158), $urandom_range(1, 118));
      b4 = xy($urandom_range(1, 158), $urandom_range(1, 118));
      t  = xy($urandom_range(1, 158), $urandom_range(1, 118));
      sel = int'($urandom_range(0, 19));
      if (sel < 12)       h = t;
      else if (sel == 12) h = b2;
      else if (sel == 13) h = xy($urandom_range(0, 1) == 0 ? 0 : 159, $urandom_range(1, 118));
      else if (sel == 14) h = xy($urandom_range(1, 158), $urandom_range(0, 1) == 0 ? 0 : 119);
      else                h = xy($urandom_range(1, 158), $urandom_range(1, 118));
      model_move(h, t, exp_p);
      do_move(h, t, r_e, r_p, r_l);
      check("rnd_early", int'(r_e),       0);
      check("rnd_pulse", int'(r_p),       int'(exp_p));
      check("rnd_late",  int'(r_l),       0);
      check("rnd_over",  int'(game_over), int'(m_over));
      check("rnd_score", int'(score),     int'(to_bcd(m_score)));
      check("rnd_len",   int'(snake_len), m_len);
      if (m_over) do_restart();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
